alu_bist: RTL and testbench
===========================

# alu_bist

Built-in self-test controller for the 4-bit, 3-bit-select combinational ALU. On a start pulse it exhaustively drives every (sel, IN0, IN1) combination into the ALU and samples OUT. It compares each result against an internal reference model, then reports pass/fail, an error count and the first failing vector. It sits beside the ALU and replaces the open-loop stimulus driver with a closed-loop, self-checking sequencer.

## Interface
Parameters:
- ALU_LAT, 0: extra cycles between driving operands and sampling OUT; use 0 for a combinational ALU.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a test run; sampled only in IDLE or DONE
- OUT  in  4  result returned by the ALU under test
- sel  out  3  operation select driven to ALU (registered)
- IN0  out  4  operand A driven to ALU (registered)
- IN1  out  4  operand B driven to ALU (registered)
- busy  out  1  run in progress
- done  out  1  run finished; held until next start or reset
- pass  out  1  done with zero errors
- err_cnt  out  12  mismatch count, saturating at 4095
- fail_sel / fail_in0 / fail_in1 / fail_out  out  3/4/4/4  first mismatching vector and the OUT value observed for it

## Operation
- Reference model (decided ALU encoding), all results truncated to 4 bits:
  - 000: IN0 & IN1
  - 001: IN0 | IN1
  - 010: IN0 ^ IN1
  - 011: ~IN0
  - 100: IN0 + IN1 (mod 16)
  - 101: IN0 - IN1 (mod 16)
  - 110: IN0 << 1, zero fill
  - 111: IN0 >> 1, zero fill
- Vector order: IN1 increments fastest, then IN0, then sel. First vector is sel=0, IN0=0, IN1=0. Last vector is sel=7, IN0=15, IN1=15. Total is 2048 vectors.
- FSM states:
  - IDLE: on start=1, clear err_cnt and all fail_* registers, load vector 0, assert busy, go to DRIVE.
  - DRIVE: operands are stable on sel/IN0/IN1. Go to WAIT if ALU_LAT>0, else to CHECK.
  - WAIT: count ALU_LAT cycles, then go to CHECK.
  - CHECK: compare OUT with the model output for the current sel/IN0/IN1.
    - On mismatch: increment err_cnt (saturating). If this is the first error, capture fail_sel/fail_in0/fail_in1/fail_out.
    - If this was the last vector, go to DONE. Otherwise advance the vector and go to DRIVE.
  - DONE: busy=0, done=1, pass=(err_cnt==0). On start=1, behave as IDLE with start (clear results, rerun).
- start is ignored in DRIVE, WAIT and CHECK.
- sel/IN0/IN1 change only on the CHECK→DRIVE transition, so they are stable throughout each vector.

## Timing
- Reset (rst_n=0 at a rising edge) forces: state IDLE, sel=0, IN0=0, IN1=0, busy=0, done=0, pass=0, err_cnt=0, all fail_*=0.
- Reset mid-run aborts immediately with the same values. No partial results are retained.
- Cycles per vector: 2+ALU_LAT.
- Run length: done rises 1+2048×(2+ALU_LAT) cycles after the edge that samples start. That is 4097 cycles for ALU_LAT=0.
- busy rises on the edge after start is sampled, and falls on the same edge that done rises.
- pass is registered together with done. pass is never 1 while done=0.
- err_cnt reflects a CHECK on the edge that ends that CHECK cycle.
- Once the first error is captured, the fail_* registers hold until the next start or reset.
- Simultaneous events:
  - start with rst_n=0: reset wins.
  - start in DONE: done and pass drop on the next edge, busy rises on the same edge.

## Test plan
- Correct behavioural ALU, ALU_LAT=0, pulse start:
  - done rises exactly 4097 cycles later.
  - pass=1, err_cnt=0, fail_* all 0.
- ALU with sel=101 implemented as IN0+IN1:
  - err_cnt=224 (the 32 vectors with IN1∈{0,8} still match).
  - fail_sel=5, fail_in0=0, fail_in1=1, fail_out=1.
  - pass=0.
- ALU returning ~expected on every vector:
  - err_cnt=2048, pass=0.
  - first fail is sel=0, in0=0, in1=0, out=F.
- Assert rst_n=0 for one cycle 100 cycles into a run:
  - next edge gives all outputs at reset values.
  - A start 5 cycles later completes normally with pass=1.
  - A start pulsed while busy has no effect on the run length.
- ALU_LAT=2 with a correct ALU: done at 8193 cycles, and OUT is sampled only in CHECK.
- After the inverting-ALU run, swap in a correct ALU and pulse start in DONE:
  - err_cnt and fail_* are cleared on the next edge.
  - The run ends with pass=1.

Source files
------------

// File: rtl/alu_bist.sv
// Closed-loop self-test sequencer for the 4-bit, 3-bit-select ALU.
// It walks all 2048 (sel, IN0, IN1) vectors, checks OUT against a reference model, and reports the results.
module alu_bist #(
   parameter int ALU_LAT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  OUT,
   output logic [2:0]  sel,
   output logic [3:0]  IN0,
   output logic [3:0]  IN1,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [11:0] err_cnt,
   output logic [2:0]  fail_sel,
   output logic [3:0]  fail_in0,
   output logic [3:0]  fail_in1,
   output logic [3:0]  fail_out
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DRIVE = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [15:0] LAT_LAST = (ALU_LAT > 0) ? 16'(ALU_LAT - 1) : 16'd0;
   localparam logic [11:0] ERR_MAX  = 12'hFFF;
   localparam logic [10:0] VEC_LAST = 11'h7FF;

   state_t      state_q, state_d;
   logic [10:0] vec_q, vec_d;
   logic [15:0] wait_q, wait_d;
   logic        start_q, start_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic [11:0] err_q, err_d;
   logic [2:0]  fsel_q, fsel_d;
   logic [3:0]  fin0_q, fin0_d;
   logic [3:0]  fin1_q, fin1_d;
   logic [3:0]  fout_q, fout_d;
   logic [3:0]  model_out;
   logic        mismatch;

   function automatic logic [3:0] alu_model(input logic [2:0] op,
                                            input logic [3:0] a,
                                            input logic [3:0] b);
      logic [3:0] r;
      case (op)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a ^ b;
         3'b011:  r = ~a;
         3'b100:  r = a + b;
         3'b101:  r = a - b;
         3'b110:  r = {a[2:0], 1'b0};
         3'b111:  r = {1'b0, a[3:1]};
         default: r = 4'h0;
      endcase
      return r;
   endfunction

   assign model_out = alu_model(vec_q[10:8], vec_q[7:4], vec_q[3:0]);
   assign mismatch  = (OUT != model_out);

   // Next-state logic; start is only registered while the controller can act on it.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      wait_d  = wait_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_d   = err_q;
      fsel_d  = fsel_q;
      fin0_d  = fin0_q;
      fin1_d  = fin1_q;
      fout_d  = fout_q;
      start_d = start & ((state_q == S_IDLE) | (state_q == S_DONE));
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_q) begin
               state_d = S_DRIVE;
               vec_d   = 11'd0;
               err_d   = 12'd0;
               fsel_d  = 3'd0;
               fin0_d  = 4'd0;
               fin1_d  = 4'd0;
               fout_d  = 4'd0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         S_DRIVE: begin
            wait_d  = 16'd0;
            state_d = (ALU_LAT > 0) ? S_WAIT : S_CHECK;
         end
         S_WAIT: begin
            if (wait_q == LAT_LAST) begin
               state_d = S_CHECK;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         S_CHECK: begin
            if (mismatch) begin
               if (err_q != ERR_MAX) begin
                  err_d = err_q + 12'd1;
               end else begin
                  err_d = err_q;
               end
               // err_q never returns to zero once it counts, so zero marks the first error.
               if (err_q == 12'd0) begin
                  fsel_d = vec_q[10:8];
                  fin0_d = vec_q[7:4];
                  fin1_d = vec_q[3:0];
                  fout_d = OUT;
               end else begin
                  fsel_d = fsel_q;
               end
            end else begin
               err_d = err_q;
            end
            if (vec_q == VEC_LAST) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_q == 12'd0) & ~mismatch;
            end else begin
               vec_d   = vec_q + 11'd1;
               state_d = S_DRIVE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and result registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         vec_q   <= 11'd0;
         wait_q  <= 16'd0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= 12'd0;
         fsel_q  <= 3'd0;
         fin0_q  <= 4'd0;
         fin1_q  <= 4'd0;
         fout_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         wait_q  <= wait_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fsel_q  <= fsel_d;
         fin0_q  <= fin0_d;
         fin1_q  <= fin1_d;
         fout_q  <= fout_d;
      end
   end

   assign sel      = vec_q[10:8];
   assign IN0      = vec_q[7:4];
   assign IN1      = vec_q[3:0];
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign err_cnt  = err_q;
   assign fail_sel = fsel_q;
   assign fail_in0 = fin0_q;
   assign fail_in1 = fin1_q;
   assign fail_out = fout_q;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: a correct ALU, two faulty ALUs, reset and restart scenarios,
// and an ALU_LAT=2 instance fed through a 3-stage pipelined ALU.
module tb_alu_bist;

   logic        clk = 1'b0;
   logic        rst_n, start, start2;
   logic [3:0]  alu_out, alu_out2;
   logic [2:0]  sel, sel2;
   logic [3:0]  in0, in1, in0_2, in1_2;
   logic        busy, done, pass, busy2, done2, pass2;
   logic [11:0] err_cnt, err2;
   logic [2:0]  fail_sel, fsel2;
   logic [3:0]  fail_in0, fail_in1, fail_out, fin0_2, fin1_2, fout2;
   logic [3:0]  p1, p2, p3;
   int          alu_mode;
   int          n_pass = 0;
   int          n_total = 0;
   int          cyc;
   logic        s0_busy, s1_busy, s1_done, s1_pass;
   logic [11:0] s1_err;
   logic [14:0] s1_fail;

   always #5 clk = ~clk;

   alu_bist #(.ALU_LAT(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .OUT(alu_out),
      .sel(sel), .IN0(in0), .IN1(in1), .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .fail_sel(fail_sel), .fail_in0(fail_in0),
      .fail_in1(fail_in1), .fail_out(fail_out));

   alu_bist #(.ALU_LAT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .OUT(alu_out2),
      .sel(sel2), .IN0(in0_2), .IN1(in1_2), .busy(busy2), .done(done2), .pass(pass2),
      .err_cnt(err2), .fail_sel(fsel2), .fail_in0(fin0_2),
      .fail_in1(fin1_2), .fail_out(fout2));

   function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         3'd3: return ~a;
         3'd4: return a + b;
         3'd5: return a - b;
         3'd6: return {a[2:0], 1'b0};
         default: return {1'b0, a[3:1]};
      endcase
   endfunction

   // mode 0: correct ALU, 1: sel=5 computes add, 2: every result inverted
   always_comb begin
      case (alu_mode)
         1:       alu_out = (sel == 3'd5) ? (in0 + in1) : alu_ref(sel, in0, in1);
         2:       alu_out = ~alu_ref(sel, in0, in1);
         default: alu_out = alu_ref(sel, in0, in1);
      endcase
   end

   always_ff @(posedge clk) begin
      p1 <= alu_ref(sel2, in0_2, in1_2);
      p2 <= p1;
      p3 <= p2;
   end
   assign alu_out2 = p3;

   task automatic run(input int pulse_at, output int n);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      s0_busy = busy;
      n = 0;
      while (n < 20000) begin
         @(posedge clk); #1;
         n++;
         start = (n == pulse_at);
         if (n == 1) begin
            s1_busy = busy; s1_done = done; s1_pass = pass; s1_err = err_cnt;
            s1_fail = {fail_sel, fail_in0, fail_in1, fail_out};
         end
         if (done) break;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; start2 = 1'b0; alu_mode = 0;
      repeat (3) @(posedge clk);
      #1;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0h want 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done got %0h want 0", done); else n_pass++;
      n_total++; if (pass !== 1'b0) $display("FAIL reset_pass got %0h want 0", pass); else n_pass++;
      n_total++; if (err_cnt !== 12'd0) $display("FAIL reset_err got %0h want 0", err_cnt); else n_pass++;
      n_total++; if ({sel, in0, in1} !== 11'd0) $display("FAIL reset_vec got %0h want 0", {sel, in0, in1}); else n_pass++;
      n_total++; if ({fail_sel, fail_in0, fail_in1, fail_out} !== 15'd0)
         $display("FAIL reset_fail got %0h want 0", {fail_sel, fail_in0, fail_in1, fail_out}); else n_pass++;
      n_total++; if ({busy2, done2, pass2} !== 3'd0) $display("FAIL reset_dut2 got %0h want 0", {busy2, done2, pass2}); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1; start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_wins_start got %0h want 0", busy); else n_pass++;
   endtask

   task automatic test_correct();
      alu_mode = 0;
      run(-1, cyc);
      n_total++; if (cyc !== 4097) $display("FAIL correct_len got %0d want 4097", cyc); else n_pass++;
      n_total++; if (s0_busy !== 1'b0) $display("FAIL busy_at_start_edge got %0h want 0", s0_busy); else n_pass++;
      n_total++; if (s1_busy !== 1'b1) $display("FAIL busy_next_edge got %0h want 1", s1_busy); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL busy_with_done got %0h want 0", busy); else n_pass++;
      n_total++; if (pass !== 1'b1) $display("FAIL correct_pass got %0h want 1", pass); else n_pass++;
      n_total++; if (err_cnt !== 12'd0) $display("FAIL correct_err got %0d want 0", err_cnt); else n_pass++;
      n_total++; if ({fail_sel, fail_in0, fail_in1, fail_out} !== 15'd0)
         $display("FAIL correct_fail got %0h want 0", {fail_sel, fail_in0, fail_in1, fail_out}); else n_pass++;
      n_total++; if ({sel, in0, in1} !== 11'h7FF) $display("FAIL last_vector got %0h want 7ff", {sel, in0, in1}); else n_pass++;
      repeat (3) @(posedge clk);
      #1;
      n_total++; if ({done, pass} !== 2'b11) $display("FAIL done_held got %0h want 3", {done, pass}); else n_pass++;
   endtask

   task automatic test_sub_fault();
      alu_mode = 1;
      run(-1, cyc);
      n_total++; if (err_cnt !== 12'd224) $display("FAIL sub_err got %0d want 224", err_cnt); else n_pass++;
      n_total++; if ({fail_sel, fail_in0, fail_in1, fail_out} !== {3'd5, 4'd0, 4'd1, 4'd1})
         $display("FAIL sub_first got %0h want %0h", {fail_sel, fail_in0, fail_in1, fail_out}, {3'd5, 4'd0, 4'd1, 4'd1}); else n_pass++;
      n_total++; if ({done, pass} !== 2'b10) $display("FAIL sub_pass got %0h want 2", {done, pass}); else n_pass++;
   endtask

   task automatic test_inverted();
      alu_mode = 2;
      run(-1, cyc);
      n_total++; if (err_cnt !== 12'd2048) $display("FAIL inv_err got %0d want 2048", err_cnt); else n_pass++;
      n_total++; if ({fail_sel, fail_in0, fail_in1, fail_out} !== {3'd0, 4'd0, 4'd0, 4'hF})
         $display("FAIL inv_first got %0h want %0h", {fail_sel, fail_in0, fail_in1, fail_out}, {3'd0, 4'd0, 4'd0, 4'hF}); else n_pass++;
      n_total++; if ({done, pass} !== 2'b10) $display("FAIL inv_pass got %0h want 2", {done, pass}); else n_pass++;
   endtask

   task automatic test_restart_clears();
      alu_mode = 0;
      run(-1, cyc);
      n_total++; if ({s1_done, s1_pass, s1_busy} !== 3'b001)
         $display("FAIL restart_flags got %0h want 1", {s1_done, s1_pass, s1_busy}); else n_pass++;
      n_total++; if (s1_err !== 12'd0) $display("FAIL restart_err_clr got %0d want 0", s1_err); else n_pass++;
      n_total++; if (s1_fail !== 15'd0) $display("FAIL restart_fail_clr got %0h want 0", s1_fail); else n_pass++;
      n_total++; if (cyc !== 4097) $display("FAIL restart_len got %0d want 4097", cyc); else n_pass++;
      n_total++; if ({pass, err_cnt} !== {1'b1, 12'd0}) $display("FAIL restart_pass got %0h want 1000", {pass, err_cnt}); else n_pass++;
   endtask

   task automatic test_mid_reset();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (100) @(negedge clk);
      n_total++; if (busy !== 1'b1) $display("FAIL midrun_busy got %0h want 1", busy); else n_pass++;
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_total++; if ({busy, done, pass} !== 3'd0) $display("FAIL abort_flags got %0h want 0", {busy, done, pass}); else n_pass++;
      n_total++; if ({sel, in0, in1} !== 11'd0) $display("FAIL abort_vec got %0h want 0", {sel, in0, in1}); else n_pass++;
      n_total++; if (err_cnt !== 12'd0) $display("FAIL abort_err got %0d want 0", err_cnt); else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      repeat (5) @(negedge clk);
      run(50, cyc);
      n_total++; if (cyc !== 4097) $display("FAIL busy_start_len got %0d want 4097", cyc); else n_pass++;
      n_total++; if ({done, pass, err_cnt} !== {2'b11, 12'd0})
         $display("FAIL rerun_result got %0h want 3000", {done, pass, err_cnt}); else n_pass++;
   endtask

   task automatic test_latency();
      int n;
      @(negedge clk); start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      n = 0;
      while (n < 20000) begin
         @(posedge clk); #1;
         n++;
         if (done2) break;
      end
      n_total++; if (n !== 8193) $display("FAIL lat2_len got %0d want 8193", n); else n_pass++;
      n_total++; if ({pass2, err2} !== {1'b1, 12'd0}) $display("FAIL lat2_result got %0h want 1000", {pass2, err2}); else n_pass++;
      n_total++; if (busy2 !== 1'b0) $display("FAIL lat2_busy got %0h want 0", busy2); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_correct();
      test_sub_fault();
      test_inverted();
      test_restart_clears();
      test_mid_reset();
      test_latency();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
